// File: rtl/tank_key_ctrl.sv
// Keyboard front end for a two-player tank game: turns PS2 make/break codes into
// per-player direction, move and rate-limited fire outputs plus a pause toggle.
// Build option TANK_KEY_AUTOFIRE_EN: a held fire key re-fires once per FIRE_PERIOD.
module tank_key_ctrl #(
   parameter int FIRE_PERIOD = 25000000
) (
   input  logic       clk_100mhz,
   input  logic       rst,
   input  logic [7:0] ascii,
   input  logic       press,
   output logic [1:0] p1_dir,
   output logic       p1_move,
   output logic       p1_fire,
   output logic [1:0] p2_dir,
   output logic       p2_move,
   output logic       p2_fire,
   output logic       paused
);

   localparam logic [7:0] K_W     = 8'h77;
   localparam logic [7:0] K_S     = 8'h73;
   localparam logic [7:0] K_A     = 8'h61;
   localparam logic [7:0] K_D     = 8'h64;
   localparam logic [7:0] K_SPACE = 8'h20;
   localparam logic [7:0] K_I     = 8'h69;
   localparam logic [7:0] K_K     = 8'h6B;
   localparam logic [7:0] K_J     = 8'h6A;
   localparam logic [7:0] K_L     = 8'h6C;
   localparam logic [7:0] K_ENTER = 8'h0D;
   localparam logic [7:0] K_P     = 8'h70;

   localparam logic [24:0] COOL_RELOAD = 25'(FIRE_PERIOD - 1);

   function automatic logic is_p1_dir(input logic [7:0] c);
      return (c == K_W) || (c == K_S) || (c == K_A) || (c == K_D);
   endfunction

   function automatic logic is_p2_dir(input logic [7:0] c);
      return (c == K_I) || (c == K_K) || (c == K_J) || (c == K_L);
   endfunction

   // Both players share the same physical layout, so one decode serves both.
   function automatic logic [1:0] dir_code(input logic [7:0] c);
      logic [1:0] d;
      case (c)
         K_W, K_I: d = 2'b00;
         K_S, K_K: d = 2'b01;
         K_A, K_J: d = 2'b10;
         default:  d = 2'b11;
      endcase
      return d;
   endfunction

   function automatic logic is_mapped(input logic [7:0] c);
      return is_p1_dir(c) || is_p2_dir(c) || (c == K_SPACE) || (c == K_ENTER) || (c == K_P);
   endfunction

   logic        prev_press;
   logic [7:0]  prev_ascii;
   logic [7:0]  last_key;
   logic        p1_move_held;
   logic        p2_move_held;
   logic [24:0] p1_cool;
   logic [24:0] p2_cool;

   logic        press_evt;
   logic        release_evt;
   logic [7:0]  nxt_last_key;
   logic        nxt_p1_move_held;
   logic        nxt_p2_move_held;
   logic [1:0]  nxt_p1_dir;
   logic [1:0]  nxt_p2_dir;
   logic        nxt_paused;
   logic        p1_fire_req;
   logic        p2_fire_req;
   logic        nxt_p1_fire;
   logic        nxt_p2_fire;
   logic [24:0] nxt_p1_cool;
   logic [24:0] nxt_p2_cool;

`ifdef TANK_KEY_AUTOFIRE_EN
   logic        p1_fire_held;
   logic        p2_fire_held;
   logic        nxt_p1_fire_held;
   logic        nxt_p2_fire_held;
`endif

   assign press_evt   = press && (!prev_press || (ascii != prev_ascii));
   assign release_evt = prev_press && !press;

   always_comb begin
      nxt_last_key     = last_key;
      nxt_p1_move_held = p1_move_held;
      nxt_p2_move_held = p2_move_held;
      nxt_p1_dir       = p1_dir;
      nxt_p2_dir       = p2_dir;
      nxt_paused       = paused;
`ifdef TANK_KEY_AUTOFIRE_EN
      nxt_p1_fire_held = p1_fire_held;
      nxt_p2_fire_held = p2_fire_held;
`endif
      if (press_evt) begin
         if (is_p1_dir(ascii)) begin
            nxt_p1_dir       = dir_code(ascii);
            nxt_p1_move_held = 1'b1;
         end
         if (is_p2_dir(ascii)) begin
            nxt_p2_dir       = dir_code(ascii);
            nxt_p2_move_held = 1'b1;
         end
         if (ascii == K_P)
            nxt_paused = !paused;
`ifdef TANK_KEY_AUTOFIRE_EN
         if (ascii == K_SPACE)
            nxt_p1_fire_held = 1'b1;
         if (ascii == K_ENTER)
            nxt_p2_fire_held = 1'b1;
`endif
         if (is_mapped(ascii))
            nxt_last_key = ascii;
      end else if (release_evt) begin
         // Only the most recently pressed key is known to be released.
         if (is_p1_dir(last_key))
            nxt_p1_move_held = 1'b0;
         if (is_p2_dir(last_key))
            nxt_p2_move_held = 1'b0;
`ifdef TANK_KEY_AUTOFIRE_EN
         if (last_key == K_SPACE)
            nxt_p1_fire_held = 1'b0;
         if (last_key == K_ENTER)
            nxt_p2_fire_held = 1'b0;
`endif
         nxt_last_key = 8'h00;
      end
   end

`ifdef TANK_KEY_AUTOFIRE_EN
   assign p1_fire_req = (press_evt && (ascii == K_SPACE)) || nxt_p1_fire_held;
   assign p2_fire_req = (press_evt && (ascii == K_ENTER)) || nxt_p2_fire_held;
`else
   assign p1_fire_req = press_evt && (ascii == K_SPACE);
   assign p2_fire_req = press_evt && (ascii == K_ENTER);
`endif

   // Cooldown keeps running while paused; requests during cooldown are dropped.
   always_comb begin
      nxt_p1_fire = 1'b0;
      nxt_p1_cool = p1_cool;
      if (p1_fire_req && (p1_cool == 25'd0) && !nxt_paused) begin
         nxt_p1_fire = 1'b1;
         nxt_p1_cool = COOL_RELOAD;
      end else if (p1_cool != 25'd0) begin
         nxt_p1_cool = p1_cool - 25'd1;
      end
   end

   always_comb begin
      nxt_p2_fire = 1'b0;
      nxt_p2_cool = p2_cool;
      if (p2_fire_req && (p2_cool == 25'd0) && !nxt_paused) begin
         nxt_p2_fire = 1'b1;
         nxt_p2_cool = COOL_RELOAD;
      end else if (p2_cool != 25'd0) begin
         nxt_p2_cool = p2_cool - 25'd1;
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         prev_press   <= 1'b0;
         prev_ascii   <= 8'h00;
         last_key     <= 8'h00;
         p1_move_held <= 1'b0;
         p2_move_held <= 1'b0;
         p1_cool      <= 25'd0;
         p2_cool      <= 25'd0;
         p1_dir       <= 2'b00;
         p2_dir       <= 2'b00;
         p1_move      <= 1'b0;
         p2_move      <= 1'b0;
         p1_fire      <= 1'b0;
         p2_fire      <= 1'b0;
         paused       <= 1'b0;
`ifdef TANK_KEY_AUTOFIRE_EN
         p1_fire_held <= 1'b0;
         p2_fire_held <= 1'b0;
`endif
      end else begin
         prev_press   <= press;
         prev_ascii   <= ascii;
         last_key     <= nxt_last_key;
         p1_move_held <= nxt_p1_move_held;
         p2_move_held <= nxt_p2_move_held;
         p1_cool      <= nxt_p1_cool;
         p2_cool      <= nxt_p2_cool;
         p1_dir       <= nxt_p1_dir;
         p2_dir       <= nxt_p2_dir;
         p1_move      <= nxt_p1_move_held && !nxt_paused;
         p2_move      <= nxt_p2_move_held && !nxt_paused;
         p1_fire      <= nxt_p1_fire;
         p2_fire      <= nxt_p2_fire;
         paused       <= nxt_paused;
`ifdef TANK_KEY_AUTOFIRE_EN
         p1_fire_held <= nxt_p1_fire_held;
         p2_fire_held <= nxt_p2_fire_held;
`endif
      end
   end

endmodule

// File: doc/tank_key_ctrl.md
TANK_KEY_CTRL -- requirements
Module: tank_key_ctrl

Interface
REQ-001 Parameter FIRE_PERIOD, default 25000000, minimum clock cycles between successive fire pulses of one player (0.25 s at 100 MHz); legal range 2..2^25-1.
REQ-002 clk_100mhz  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 ascii  input  8  key code from the PS2 decoder; 0x00 on release or unmapped key.
REQ-005 press  input  1  from the PS2 decoder; 1 while the last event is a make, 0 after a break.
REQ-006 p1_dir  output  2  player-1 direction: 00 up, 01 down, 10 left, 11 right.
REQ-007 p1_move  output  1  player-1 direction key held and not paused.
REQ-008 p1_fire  output  1  player-1 single-cycle fire pulse.
REQ-009 p2_dir, p2_move, p2_fire  output  2/1/1  player-2 equivalents of REQ-006..008.
REQ-010 paused  output  1  pause state.

Function
REQ-011 Key map: P1 w=0x77 up, s=0x73 down, a=0x61 left, d=0x64 right, fire space=0x20; P2 i=0x69 up, k=0x6B down, j=0x6A left, l=0x6C right, fire Enter=0x0D; pause p=0x70; all other codes are ignored.
REQ-012 Block registers {press, ascii} every cycle as prev; press event = press==1 and (prev press==0 or ascii!=prev ascii); release event = prev press==1 and press==0.
REQ-013 Identical repeated input (typematic) generates no event.
REQ-014 On a press event with a mapped code, last_key is loaded with that code; on a release event, the held state of the key in last_key is cleared and last_key is set to 0x00.
REQ-015 Direction press event: the player's dir updates to the new value and move_held is set; a release of that player's direction key clears move_held; dir holds its last value.
REQ-016 pN_move = move_held AND NOT paused.
REQ-017 Each player has a 25-bit cooldown counter; it decrements by 1 per cycle while nonzero and saturates at 0.
REQ-018 Fire press event with cooldown==0 and not paused: pN_fire=1 for exactly one cycle and cooldown loads FIRE_PERIOD-1; with cooldown!=0 the press is dropped, not queued.
REQ-019 Pause press event toggles paused; while paused, fire pulses are suppressed and the cooldown still counts; held state keeps tracking presses and releases.
REQ-020 Outputs are registered; response appears on the first rising edge after the input change (1-cycle latency).
REQ-021 Both players operate independently; a P1 event never alters P2 state and vice versa.
REQ-022 A press event for one player's key while another key is held replaces last_key; the earlier key's held state stays set until a subsequent release event clears the key in last_key, or until reset.

Reset
REQ-023 When rst=1 at a clock edge: p1_dir=p2_dir=00, all move/fire outputs 0, paused 0, cooldowns 0, held flags 0, last_key 0x00, prev {0,0x00}.
REQ-024 rst overrides any event on the same edge; a fire pulse in flight is truncated, and the first cycle after reset performs no edge detection against stale prev.

Configuration
REQ-025 Macro TANK_KEY_AUTOFIRE_EN: when defined, a held fire key (fire_held=1, not paused) emits a new pulse each time cooldown reaches 0 and reloads it, giving one pulse per FIRE_PERIOD; when undefined, exactly one pulse per fire press event and fire_held is not used.

Verification
REQ-026 Reset, then ascii=0x77 press=1 -> next cycle p1_dir=00, p1_move=1; then press=0 ascii=0x00 -> p1_move=0, p1_dir stays 00.
REQ-027 FIRE_PERIOD=8: space press, release after 2 cycles, press again 3 cycles later -> only the first pulse appears; a press at least 8 cycles after the first pulse -> second pulse.
REQ-028 TANK_KEY_AUTOFIRE_EN defined, FIRE_PERIOD=8, space held 40 cycles -> pulses at cycles 1, 9, 17, 25, 33 relative to press; undefined -> a single pulse.
REQ-029 0x70 press, release, then 0x6C press -> paused=1, p2_dir=11, p2_move=0; second 0x70 press -> paused=0, p2_move=1.
REQ-030 Enter pressed and rst asserted on the same cycle as the press event -> p2_fire stays 0 and all outputs hold reset values the next cycle.
